frv_dmem_arbiter: RTL and testbench

//  Two-requester arbiter for the single data memory port. Port 0 is the load/store unit;

---
 rtl/frv_dmem_arbiter_if.sv | 25 ++
 rtl/frv_dmem_arbiter.sv | 86 ++++++++
 tb/tb_frv_dmem_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/frv_dmem_arbiter_if.sv
// Request/response bundle for one data-memory port: the requester drives the
// request fields, the responder drives stall and the one-cycle-late response.
interface frv_dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic              cen;
    logic              wen;
    logic [DW/8-1:0]   strb;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic              stall;
    logic              error;
    logic [DW-1:0]     rdata;

    modport master (
        output cen, wen, strb, addr, wdata,
        input  stall, error, rdata
    );

    modport slave (
        input  cen, wen, strb, addr, wdata,
        output stall, error, rdata
    );
endinterface

// File: rtl/frv_dmem_arbiter.sv
// Two-port arbiter in front of the single data-memory port; holds a grant across
// memory stalls and steers each response back to its issuer.
// Define FRV_DMEM_ARB_RR_EN for round-robin tie-breaking; default is port0-first.
module frv_dmem_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    frv_dmem_arbiter_if.slave    p0,
    frv_dmem_arbiter_if.slave    p1,
    frv_dmem_arbiter_if.master   dmem
);

    logic lock_q, lock_d;
    logic lock_id_q, lock_id_d;
    logic rsp_vld_q, rsp_vld_d;
    logic rsp_id_q, rsp_id_d;
    logic prio_q, prio_d;

    logic            grant;
    logic            accept;
    logic            both_req;
    logic [AW-1:0]   addr_mux;
    logic [DW-1:0]   wdata_mux;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= 1'b0;
            prio_q    <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
            prio_q    <= prio_d;
        end
    end

    // A locked (stalled) owner always keeps the bus, even against a favoured arrival.
    always_comb begin
        both_req = p0.cen & p1.cen;
        if (lock_q) begin
            grant = lock_id_q;
        end else if (both_req) begin
            grant = prio_q;
        end else begin
            grant = p1.cen;
        end
    end

    always_comb begin
        dmem.cen   = grant ? p1.cen  : p0.cen;
        dmem.wen   = grant ? p1.wen  : p0.wen;
        dmem.strb  = grant ? p1.strb : p0.strb;
        addr_mux   = grant ? p1.addr : p0.addr;
        wdata_mux  = grant ? p1.wdata : p0.wdata;
        dmem.addr  = addr_mux;
        dmem.wdata = wdata_mux;
        accept     = dmem.cen & ~dmem.stall;

        p0.stall   = p0.cen & (grant  ? 1'b1 : dmem.stall);
        p1.stall   = p1.cen & (!grant ? 1'b1 : dmem.stall);

        p0.rdata   = (rsp_vld_q && !rsp_id_q) ? dmem.rdata : '0;
        p0.error   = rsp_vld_q & ~rsp_id_q & dmem.error;
        p1.rdata   = (rsp_vld_q && rsp_id_q) ? dmem.rdata : '0;
        p1.error   = rsp_vld_q & rsp_id_q & dmem.error;
    end

    always_comb begin
        lock_d    = dmem.cen & dmem.stall;
        lock_id_d = (dmem.cen && dmem.stall) ? grant : lock_id_q;
        rsp_vld_d = accept;
        rsp_id_d  = accept ? grant : rsp_id_q;
`ifdef FRV_DMEM_ARB_RR_EN
        prio_d    = (accept && both_req) ? ~grant : prio_q;
`else
        prio_d    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// Randomized bench for frv_dmem_arbiter: a cycle-level reference of the arbitration
// rules plus a response scoreboard, and a directed reset-during-lock episode.
module tb_frv_dmem_arbiter;

    logic g_clk;
    logic g_resetn;

    frv_dmem_arbiter_if #(.AW(32), .DW(32)) p0_bus ();
    frv_dmem_arbiter_if #(.AW(32), .DW(32)) p1_bus ();
    frv_dmem_arbiter_if #(.AW(32), .DW(32)) mem_bus ();

    frv_dmem_arbiter #(.AW(32), .DW(32)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .p0       (p0_bus),
        .p1       (p1_bus),
        .dmem     (mem_bus)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    int checks = 0;
    int errors = 0;
    bit stop_new = 0;
    bit acc0 = 0;
    bit acc1 = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: who owns a stalled request, who is favoured on a tie,
    // and which port each outstanding response belongs to.
    bit owner_valid = 0;
    bit owner_id = 0;
    bit favoured = 0;
    bit rsp_q[$];

    initial begin
        bit          win;
        bit          exp_cen;
        bit          c0, c1;
        bit          has_rsp, rsp_port;
        logic [68:0] req0, req1, bus;
        forever begin
            @(negedge g_clk);
            if (!g_resetn) begin
                owner_valid = 0;
                owner_id    = 0;
                favoured    = 0;
                rsp_q.delete();
                acc0 = 0;
                acc1 = 0;
            end else begin
                c0 = p0_bus.cen;
                c1 = p1_bus.cen;
                if (owner_valid)  win = owner_id;
                else if (c0 && c1) win = favoured;
                else               win = c1;
                exp_cen = c0 | c1;
                check("dmem_cen", mem_bus.cen, exp_cen);
                req0 = {p0_bus.wen, p0_bus.strb, p0_bus.addr, p0_bus.wdata};
                req1 = {p1_bus.wen, p1_bus.strb, p1_bus.addr, p1_bus.wdata};
                bus  = {mem_bus.wen, mem_bus.strb, mem_bus.addr, mem_bus.wdata};
                if (exp_cen) check("dmem_req", bus, win ? req1 : req0);
                check("p0_stall", p0_bus.stall, c0 && (win || mem_bus.stall));
                check("p1_stall", p1_bus.stall, c1 && (!win || mem_bus.stall));

                has_rsp  = rsp_q.size() > 0;
                rsp_port = has_rsp ? rsp_q.pop_front() : 1'b0;
                check("p0_rdata", p0_bus.rdata, (has_rsp && !rsp_port) ? mem_bus.rdata : 32'h0);
                check("p0_error", p0_bus.error, has_rsp && !rsp_port && mem_bus.error);
                check("p1_rdata", p1_bus.rdata, (has_rsp && rsp_port) ? mem_bus.rdata : 32'h0);
                check("p1_error", p1_bus.error, has_rsp && rsp_port && mem_bus.error);

                if (exp_cen && !mem_bus.stall) begin
                    rsp_q.push_back(win);
`ifdef FRV_DMEM_ARB_RR_EN
                    if (c0 && c1) favoured = ~win;
`endif
                    owner_valid = 0;
                end else if (exp_cen) begin
                    owner_valid = 1;
                    owner_id    = win;
                end
                acc0 = p0_bus.cen && !p0_bus.stall;
                acc1 = p1_bus.cen && !p1_bus.stall;
            end
        end
    end

    task automatic rand_mem();
        mem_bus.stall = ($urandom_range(0, 3) == 0);
        mem_bus.rdata = $urandom;
        mem_bus.error = ($urandom_range(0, 7) == 0);
    endtask

    task automatic rand_step();
        @(posedge g_clk);
        #1;
        if (!p0_bus.cen || acc0) begin
            p0_bus.cen   = !stop_new && ($urandom_range(0, 2) != 0);
            p0_bus.wen   = $urandom_range(0, 1);
            p0_bus.strb  = $urandom_range(0, 15);
            p0_bus.addr  = $urandom;
            p0_bus.wdata = $urandom;
        end
        if (!p1_bus.cen || acc1) begin
            p1_bus.cen   = !stop_new && ($urandom_range(0, 2) != 0);
            p1_bus.wen   = $urandom_range(0, 1);
            p1_bus.strb  = $urandom_range(0, 15);
            p1_bus.addr  = $urandom;
            p1_bus.wdata = $urandom;
        end
        rand_mem();
    endtask

    initial begin
        g_resetn      = 1'b0;
        p0_bus.cen    = 0; p0_bus.wen = 0; p0_bus.strb = 0; p0_bus.addr = 0; p0_bus.wdata = 0;
        p1_bus.cen    = 0; p1_bus.wen = 0; p1_bus.strb = 0; p1_bus.addr = 0; p1_bus.wdata = 0;
        mem_bus.stall = 0;
        mem_bus.rdata = 32'hDEAD_BEEF;
        mem_bus.error = 1'b1;
        #12;
        check("rst_p0_rdata", p0_bus.rdata, 32'h0);
        check("rst_p1_rdata", p1_bus.rdata, 32'h0);
        check("rst_p0_error", p0_bus.error, 1'b0);
        check("rst_p1_error", p1_bus.error, 1'b0);
        check("rst_dmem_cen", mem_bus.cen, 1'b0);
        @(posedge g_clk);
        #3 g_resetn = 1'b1;

        for (int i = 0; i < 2000; i++) rand_step();

        // Drain outstanding requests, then build a locked stall and reset through it.
        stop_new = 1;
        for (int i = 0; i < 100 && (p0_bus.cen || p1_bus.cen); i++) rand_step();
        check("drain_timeout", {p0_bus.cen, p1_bus.cen}, 2'b00);
        stop_new = 0;

        @(posedge g_clk); #1;
        p1_bus.cen = 1; p1_bus.wen = 0; p1_bus.addr = 32'h0000_2000; p1_bus.wdata = 32'h0;
        mem_bus.stall = 1;
        @(posedge g_clk); #1;
        p0_bus.cen = 1; p0_bus.wen = 0; p0_bus.addr = 32'h0000_1000; p0_bus.wdata = 32'h0;
        @(posedge g_clk); #1;
        check("lock_addr", mem_bus.addr, 32'h0000_2000);
        check("lock_p0_stall", p0_bus.stall, 1'b1);
        #2 g_resetn = 1'b0;
        #1;
        check("rstlock_cen", mem_bus.cen, 1'b1);
        check("rstlock_addr", mem_bus.addr, 32'h0000_1000);
        check("rstlock_p1_stall", p1_bus.stall, 1'b1);
        check("rstlock_p0_rdata", p0_bus.rdata, 32'h0);
        check("rstlock_p1_rdata", p1_bus.rdata, 32'h0);
        mem_bus.stall = 0;
        @(posedge g_clk);
        #3 g_resetn = 1'b1;
        #1;
        check("postrst_tie_addr", mem_bus.addr, 32'h0000_1000);
        check("postrst_p1_stall", p1_bus.stall, 1'b1);

        for (int i = 0; i < 200; i++) rand_step();

        @(negedge g_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
